// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the pipeline stage register.
//   ctrl_t        : decoded control bundle carried alongside the payload.
//                   Bit 0 (reg_dest_data_writeback) is the write-back enable.
//   CTRL_WIDTH    : packed width of ctrl_t; the default control width of the stage.
//   DATA_ALU_LSB / DATA_MEM_LSB : default payload layout (ALU result low half,
//                   memory data high half).
//   stage_state_t : occupancy of the skid-buffered stage.
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef struct packed {
    logic       wbs;
    logic [1:0] mm;
    logic       wm;
    logic       ni;
    logic       wce;
    logic       wme1;
    logic       wme2;
    logic       reg_dest;
    logic       reg_dest_data_writeback;
  } ctrl_t;

  localparam int CTRL_WIDTH   = $bits(ctrl_t);
  localparam int DATA_ALU_LSB = 0;
  localparam int DATA_MEM_LSB = 16;

  // EMPTY: nothing held; BUSY: main register full; FULL: main and skid full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// One-entry skid buffer plus occupancy FSM for the registered-ready build of
// pipe_stage_reg. The main output register lives in the parent; this block
// tells the parent when to load it (and from where) or clear it.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ctrl/in_data : upstream entry
//   flush                : drop everything held, return to EMPTY
//   out_ready            : downstream accepts the main register this cycle
//   in_ready             : registered ready to upstream (no path from out_ready)
//   main_ld              : load main register with ld_ctrl/ld_data
//   main_clr             : invalidate main register (takes priority over main_ld)
//   ld_ctrl/ld_data      : entry to load (upstream or skid)
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              out_ready,
  output logic              in_ready,
  output logic              main_ld,
  output logic              main_clr,
  output logic [CTRL_W-1:0] ld_ctrl,
  output logic [DATA_W-1:0] ld_data
);

  stage_state_t      state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_xfer, out_xfer;

  // in_ready_q always equals (state_q != FULL), so no input transfer can
  // happen in FULL.
  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = (state_q != EMPTY) && out_ready;
  assign in_ready = in_ready_q;

  always_comb begin
    state_d     = state_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    main_ld     = 1'b0;
    main_clr    = 1'b0;
    ld_ctrl     = in_ctrl;
    ld_data     = in_data;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = BUSY;
            main_ld = 1'b1;
          end
        end
        BUSY: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              // main is stuck, park the new entry in the skid slot
              state_d     = FULL;
              skid_ctrl_d = in_ctrl;
              skid_data_d = in_data;
            end
            2'b01: begin
              state_d  = EMPTY;
              main_clr = 1'b1;
            end
            2'b11:   main_ld = 1'b1;  // replace in place, no bubble
            default: ;
          endcase
        end
        FULL: begin
          if (out_xfer) begin
            state_d = BUSY;
            main_ld = 1'b1;
            ld_ctrl = skid_ctrl_q;
            ld_data = skid_data_q;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
        end
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage register for a control bundle plus payload, with
// flush and a saturating back-pressure counter.
// Build option: define PIPE_STAGE_SKID_EN for a registered in_ready backed by
// a one-entry skid buffer (pipe_skid_buf). Without it the stage is a single
// register whose in_ready combinationally follows out_ready.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : upstream handshake
//   in_ctrl/in_data       : upstream entry
//   flush                 : kill all held entries (out_data keeps its value)
//   out_valid/out_ready   : downstream handshake
//   out_ctrl/out_data     : registered entry; out_ctrl is zero when invalid
//   stall_cnt             : saturating count of out_valid && !out_ready edges
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              main_ld, main_clr;
  logic [CTRL_W-1:0] ld_ctrl;
  logic [DATA_W-1:0] ld_data;

`ifdef PIPE_STAGE_SKID_EN
  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .main_ld   (main_ld),
    .main_clr  (main_clr),
    .ld_ctrl   (ld_ctrl),
    .ld_data   (ld_data)
  );
`else
  // Single register: accept whenever the slot is free or being drained.
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    main_ld  = in_valid && in_ready && !flush;
    main_clr = flush || (out_valid_q && out_ready && !main_ld);
    ld_ctrl  = in_ctrl;
    ld_data  = in_data;
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    // Invalidating zeroes ctrl so a bubble carries no write enables; data is
    // left alone.
    if (main_clr) begin
      out_valid_d = 1'b0;
      ctrl_d      = '0;
    end else if (main_ld) begin
      out_valid_d = 1'b1;
      ctrl_d      = ld_ctrl;
      data_d      = ld_data;
    end

    stall_cnt_d = stall_cnt_q;
    if (!flush && out_valid_q && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. Two instances share the stimulus: one with the
// default counter width and one with CNT_W=3 to exercise saturation.
// The reference model is a queue of held entries with a capacity of 1 (plain
// build) or 2 (skid build).
module tb_pipe_stage_reg;
  localparam int CW = 10;
  localparam int DW = 32;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, out_valid, in_ready3, out_valid3;
  logic [CW-1:0] out_ctrl, out_ctrl3;
  logic [DW-1:0] out_data, out_data3;
  logic [15:0]   stall_cnt;
  logic [2:0]    stall_cnt3;

  pipe_stage_reg u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid3), .out_ready(out_ready), .out_ctrl(out_ctrl3),
    .out_data(out_data3), .stall_cnt(stall_cnt3)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t mq[$];
  int   m_cnt = 0;
  int   m_cnt3 = 0;
  bit   m_acc = 1'b0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  ent_t obs_q[$];
  int   obs_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit exp_ir();
    return SKID ? (mq.size() < 2) : (mq.size() == 0 || out_ready);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: advance the held-entry queue on each edge.
  always @(posedge clk) begin
    bit ov, ir;
    cyc++;
    m_acc = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_cnt  = 0;
      m_cnt3 = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      ov = (mq.size() > 0);
      ir = exp_ir();
      if (ov && !out_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      if (ov && out_ready) void'(mq.pop_front());
      if (in_valid && ir) begin
        mq.push_back(ent_t'({in_ctrl, in_data}));
        m_acc = 1'b1;
      end
    end
  end

  // Monitor: compare what the DUT presents against the head of the queue.
  always @(negedge clk) begin
    ent_t e;
    bit   v;
    if (chk_en) begin
      v = (mq.size() > 0);
      e = v ? mq[0] : '0;
      chk("out_valid", 64'(out_valid), 64'(v));
      chk("out_valid3", 64'(out_valid3), 64'(v));
      chk("in_ready", 64'(in_ready), 64'(exp_ir()));
      chk("in_ready3", 64'(in_ready3), 64'(exp_ir()));
      chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
      chk("out_ctrl3", 64'(out_ctrl3), 64'(e.c));
      if (v) begin
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_data3", 64'(out_data3), 64'(e.d));
      end
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      chk("stall_cnt3", 64'(stall_cnt3), 64'(m_cnt3));
      if (rst_n && !flush && out_valid && out_ready) begin
        obs_q.push_back(ent_t'({out_ctrl, out_data}));
        obs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ent_t items[3];
    ent_t sitems[8];
    ent_t got;
    int   idx;
    int   acc;

    // reset
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    chk("valid_after_reset", 64'(out_valid), 64'd0);

    // single entry, 1-cycle latency
    in_valid = 1'b1; in_ctrl = 10'h3FF; in_data = 32'h1234_ABCD; out_ready = 1'b1;
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_ctrl", 64'(out_ctrl), 64'h3FF);
    chk("lat_data", 64'(out_data), 64'h1234_ABCD);

    // stall: hold stable, count, saturate the narrow counter
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (5) tick();
    chk("stall5_cnt", 64'(stall_cnt), 64'd5);
    chk("stall5_cnt3", 64'(stall_cnt3), 64'd5);
    chk("stall5_data", 64'(out_data), 64'h1234_ABCD);
    chk("stall5_ctrl", 64'(out_ctrl), 64'h3FF);
    repeat (5) tick();
    chk("stall10_cnt", 64'(stall_cnt), 64'd10);
    chk("stall10_cnt3_sat", 64'(stall_cnt3), 64'd7);

    // flush beats a simultaneous input
    in_valid = 1'b1; in_ctrl = 10'h155; in_data = 32'hDEAD_BEEF; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_cnt_hold", 64'(stall_cnt), 64'd10);
    chk("flush_data_kept", 64'(out_data), 64'h1234_ABCD);

    // reset during a stall with stall_cnt=4
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    in_valid = 1'b1; in_ctrl = 10'h0F0; in_data = 32'h5555_0000; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre_rst_cnt", 64'(stall_cnt), 64'd4);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_data", 64'(out_data), 64'd0);

    // A, B, C back to back under back-pressure, then drain
    items[0] = ent_t'({10'h001, 32'hAAAA_0001});
    items[1] = ent_t'({10'h002, 32'hBBBB_0002});
    items[2] = ent_t'({10'h003, 32'hCCCC_0003});
    obs_q.delete(); obs_cyc.delete();
    out_ready = 1'b0; idx = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) chk("c_blocked_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1; {in_ctrl, in_data} = items[idx];
      tick();
      if (m_acc) idx++;
    end
    chk("accepted_under_stall", 64'(idx), SKID ? 64'd2 : 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (idx < 3) begin
        in_valid = 1'b1; {in_ctrl, in_data} = items[idx];
      end else in_valid = 1'b0;
      tick();
      if (m_acc) idx++;
    end
    chk("abc_count", 64'(obs_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      chk("abc_order", 64'(got), 64'(items[i]));
    end

    // streaming 8 entries, no bubbles
    obs_q.delete(); obs_cyc.delete(); acc = 0;
    for (int k = 0; k < 8; k++) sitems[k] = ent_t'({10'($urandom), 32'($urandom)});
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; out_ready = 1'b1; {in_ctrl, in_data} = sitems[k];
      tick();
      if (m_acc) acc++;
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("stream_accepted", 64'(acc), 64'd8);
    chk("stream_count", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      chk("stream_data", 64'(got), 64'(sitems[i]));
      chk("stream_consecutive", 64'((i < obs_cyc.size()) ? obs_cyc[i] - obs_cyc[0] : -1), 64'(i));
    end

    // randomized traffic with occasional flush and reset
    for (int k = 0; k < 600; k++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ((k / 50) % 4 == 3) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      if (!(in_valid && !m_acc)) begin
        in_ctrl = 10'($urandom);
        in_data = $urandom;
      end
      in_valid = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
